// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: state codes,
// opcodes and datapath select values.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        HALT     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        logic [1:0] sel;
        case (op)
            OP_SW:   sel = IMM_S;
            OP_BEQ:  sel = IMM_B;
            OP_JAL:  sel = IMM_J;
            default: sel = IMM_I;
        endcase
        return sel;
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts cycles a memory state spends waiting for ready and flags the
// cycle in which the wait limit is reached without ready.
import mc_pkg::*;

module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,
    input  logic i_ready,
    output logic o_expired
);

    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic             waiting;

    assign waiting   = i_active && !i_ready;
    // ready in the limit cycle masks the timeout
    assign o_expired = TIMEOUT_EN && waiting && (cnt_q == LIMIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (!waiting || o_expired) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core (lw, sw, R, I-ALU, beq, jal)
// with memory ready handshake, wait timeout and sticky halt.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4 on ready
// DECODE   | compute branch/jump target from old PC + imm
// MEMADR   | compute rs1 + imm for lw/sw
// MEMREAD  | read data memory, wait for ready
// MEMWB    | write loaded data to rd
// MEMWRITE | write data memory, wait for ready
// EXECR    | ALU rs1 op rs2
// EXECI    | ALU rs1 op imm
// ALUWB    | write ALU result to rd
// BEQ      | compare rs1/rs2, take branch on zero
// JAL      | PC <= target, compute old PC + 4
// HALT     | stopped on illegal opcode or bus timeout
import mc_pkg::*;

module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_op,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_memwrite,
    output logic       o_adrsrc,
    output logic       o_irwrite,
    output logic       o_pcwrite,
    output logic       o_regwrite,
    output logic [1:0] o_resultsrc,
    output logic [1:0] o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_immsrc,
    output logic [1:0] o_aluop,
    output logic       o_instret,
    output logic       o_halted,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    state_t state_q;
    state_t state_d;
    logic   halted_q;
    logic   illegal_q;
    logic   expired;
    logic   illegal_op;
    logic   pcupdate;
    logic   branch;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_wait_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_active (is_mem_state(state_q)),
        .i_ready  (i_mem_ready),
        .o_expired(expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= FETCH;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == HALT) begin
                halted_q <= 1'b1;
            end
            if (illegal_op) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                if (expired)          state_d = HALT;
                else if (i_mem_ready) state_d = DECODE;
            end
            DECODE: begin
                case (i_op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        state_d    = HALT;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR:   state_d = (i_op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD: begin
                if (expired)          state_d = HALT;
                else if (i_mem_ready) state_d = MEMWB;
            end
            MEMWB:    state_d = FETCH;
            MEMWRITE: begin
                if (expired)          state_d = HALT;
                else if (i_mem_ready) state_d = FETCH;
            end
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
            HALT:     state_d = HALT;
            default:  state_d = HALT;
        endcase
    end

    always_comb begin
        o_mem_req   = 1'b0;
        o_memwrite  = 1'b0;
        o_adrsrc    = 1'b0;
        o_irwrite   = 1'b0;
        o_regwrite  = 1'b0;
        o_resultsrc = RES_ALUOUT;
        o_alusrca   = SRCA_PC;
        o_alusrcb   = SRCB_RS2;
        o_aluop     = ALUOP_ADD;
        o_instret   = 1'b0;
        pcupdate    = 1'b0;
        branch      = 1'b0;
        case (state_q)
            FETCH: begin
                o_mem_req   = 1'b1;
                o_alusrcb   = SRCB_FOUR;
                o_resultsrc = RES_ALU;
                o_irwrite   = i_mem_ready;
                pcupdate    = i_mem_ready;
            end
            DECODE: begin
                o_alusrca = SRCA_OLDPC;
                o_alusrcb = SRCB_IMM;
            end
            MEMADR: begin
                o_alusrca = SRCA_RS1;
                o_alusrcb = SRCB_IMM;
            end
            MEMREAD: begin
                o_mem_req = 1'b1;
                o_adrsrc  = 1'b1;
            end
            MEMWB: begin
                o_resultsrc = RES_DATA;
                o_regwrite  = 1'b1;
                o_instret   = 1'b1;
            end
            MEMWRITE: begin
                o_mem_req  = 1'b1;
                o_memwrite = 1'b1;
                o_adrsrc   = 1'b1;
                o_instret  = i_mem_ready;
            end
            EXECR: begin
                o_alusrca = SRCA_RS1;
                o_alusrcb = SRCB_RS2;
                o_aluop   = ALUOP_FUNCT;
            end
            EXECI: begin
                o_alusrca = SRCA_RS1;
                o_alusrcb = SRCB_IMM;
                o_aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                o_regwrite = 1'b1;
                o_instret  = 1'b1;
            end
            BEQ: begin
                o_alusrca = SRCA_RS1;
                o_alusrcb = SRCB_RS2;
                o_aluop   = ALUOP_SUB;
                branch    = 1'b1;
                o_instret = 1'b1;
            end
            JAL: begin
                o_alusrca = SRCA_OLDPC;
                o_alusrcb = SRCB_FOUR;
                pcupdate  = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_pcwrite = pcupdate | (branch & i_zero);
    assign o_immsrc  = imm_sel(i_op);
    assign o_halted  = halted_q;
    assign o_illegal = illegal_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a short (4-cycle) memory timeout.
module tb_multicycle_ctrl;

    localparam logic [6:0] T_LW   = 7'b0000011;
    localparam logic [6:0] T_SW   = 7'b0100011;
    localparam logic [6:0] T_R    = 7'b0110011;
    localparam logic [6:0] T_I    = 7'b0010011;
    localparam logic [6:0] T_BEQ  = 7'b1100011;
    localparam logic [6:0] T_JAL  = 7'b1101111;
    localparam logic [6:0] T_SYS  = 7'b1110011;

    // {state, mem_req, adrsrc, memwrite, irwrite, pcwrite, regwrite, instret, resultsrc}
    localparam logic [12:0] V_F1    = {4'd0,  7'b1001100, 2'b10};
    localparam logic [12:0] V_F0    = {4'd0,  7'b1000000, 2'b10};
    localparam logic [12:0] V_DEC   = {4'd1,  7'b0000000, 2'b00};
    localparam logic [12:0] V_MADR  = {4'd2,  7'b0000000, 2'b00};
    localparam logic [12:0] V_MRD1  = {4'd3,  7'b1100000, 2'b00};
    localparam logic [12:0] V_MWB   = {4'd4,  7'b0000011, 2'b01};
    localparam logic [12:0] V_MWR0  = {4'd5,  7'b1110000, 2'b00};
    localparam logic [12:0] V_MWR1  = {4'd5,  7'b1110001, 2'b00};
    localparam logic [12:0] V_EXR   = {4'd6,  7'b0000000, 2'b00};
    localparam logic [12:0] V_EXI   = {4'd7,  7'b0000000, 2'b00};
    localparam logic [12:0] V_ALUWB = {4'd8,  7'b0000011, 2'b00};
    localparam logic [12:0] V_BEQT  = {4'd9,  7'b0000101, 2'b00};
    localparam logic [12:0] V_BEQN  = {4'd9,  7'b0000001, 2'b00};
    localparam logic [12:0] V_JAL   = {4'd10, 7'b0000100, 2'b00};
    localparam logic [12:0] V_HALT  = {4'd15, 7'b0000000, 2'b00};

    logic       i_clk;
    logic       i_rst_n;
    logic [6:0] i_op;
    logic       i_zero;
    logic       i_mem_ready;
    logic       o_mem_req;
    logic       o_memwrite;
    logic       o_adrsrc;
    logic       o_irwrite;
    logic       o_pcwrite;
    logic       o_regwrite;
    logic [1:0] o_resultsrc;
    logic [1:0] o_alusrca;
    logic [1:0] o_alusrcb;
    logic [1:0] o_immsrc;
    logic [1:0] o_aluop;
    logic       o_instret;
    logic       o_halted;
    logic       o_illegal;
    logic [3:0] o_state;

    int vectors;
    int miscompares;

    multicycle_ctrl #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (5)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_op       (i_op),
        .i_zero     (i_zero),
        .i_mem_ready(i_mem_ready),
        .o_mem_req  (o_mem_req),
        .o_memwrite (o_memwrite),
        .o_adrsrc   (o_adrsrc),
        .o_irwrite  (o_irwrite),
        .o_pcwrite  (o_pcwrite),
        .o_regwrite (o_regwrite),
        .o_resultsrc(o_resultsrc),
        .o_alusrca  (o_alusrca),
        .o_alusrcb  (o_alusrcb),
        .o_immsrc   (o_immsrc),
        .o_aluop    (o_aluop),
        .o_instret  (o_instret),
        .o_halted   (o_halted),
        .o_illegal  (o_illegal),
        .o_state    (o_state)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [12:0] ctrl_vec();
        return {o_state, o_mem_req, o_adrsrc, o_memwrite, o_irwrite,
                o_pcwrite, o_regwrite, o_instret, o_resultsrc};
    endfunction

    function automatic logic [7:0] sel_vec();
        return {o_alusrca, o_alusrcb, o_aluop, o_immsrc};
    endfunction

    task automatic drive(input logic [6:0] op, input logic rdy, input logic zero);
        @(negedge i_clk);
        i_op        = op;
        i_mem_ready = rdy;
        i_zero      = zero;
        #1;
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_rst_n     = 1'b0;
        i_mem_ready = 1'b0;
        #1;
        vectors++;
        if ({ctrl_vec(), o_halted, o_illegal} !== {V_F0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got %b/%b%b expected %b/00", ctrl_vec(), o_halted, o_illegal, V_F0);
        end
        vectors++;
        if (o_alusrcb !== 2'b10 || o_alusrca !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_alusrc: got a=%b b=%b expected a=00 b=10", o_alusrca, o_alusrcb);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_lw();
        logic [12:0] exp_v [6];
        logic [5:0]  rdy;
        int          pulses;
        exp_v  = '{V_F1, V_DEC, V_MADR, V_MRD1, V_MWB, V_F0};
        rdy    = 6'b011111;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            drive(T_LW, rdy[c], 1'b0);
            pulses += int'(o_instret);
            vectors++;
            if (ctrl_vec() !== exp_v[c]) begin
                miscompares++;
                $display("FAIL lw cycle %0d: got %b expected %b", c, ctrl_vec(), exp_v[c]);
            end
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL lw_instret_count: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_sw();
        logic [12:0] exp_v [8];
        logic [7:0]  rdy;
        exp_v = '{V_F1, V_DEC, V_MADR, V_MWR0, V_MWR0, V_MWR0, V_MWR1, V_F0};
        rdy   = 8'b01000111;
        for (int c = 0; c < 8; c++) begin
            drive(T_SW, rdy[c], 1'b0);
            vectors++;
            if (ctrl_vec() !== exp_v[c]) begin
                miscompares++;
                $display("FAIL sw cycle %0d: got %b expected %b", c, ctrl_vec(), exp_v[c]);
            end
        end
    endtask

    task automatic test_beq(input logic zero);
        logic [12:0] exp_v [4];
        exp_v = '{V_F1, V_DEC, (zero ? V_BEQT : V_BEQN), V_F0};
        for (int c = 0; c < 4; c++) begin
            drive(T_BEQ, (c == 0), zero);
            vectors++;
            if (ctrl_vec() !== exp_v[c]) begin
                miscompares++;
                $display("FAIL beq z=%0b cycle %0d: got %b expected %b", zero, c, ctrl_vec(), exp_v[c]);
            end
            if (c == 2) begin
                vectors++;
                if (sel_vec() !== 8'b10_00_01_10) begin
                    miscompares++;
                    $display("FAIL beq_sel: got %b expected 10000110", sel_vec());
                end
            end
        end
    endtask

    task automatic test_jal();
        logic [12:0] exp_v [5];
        logic [7:0]  exp_s [5];
        exp_v = '{V_F1, V_DEC, V_JAL, V_ALUWB, V_F0};
        exp_s = '{8'b00_10_00_11, 8'b01_01_00_11, 8'b01_10_00_11, 8'b00_00_00_11, 8'b00_10_00_11};
        for (int c = 0; c < 5; c++) begin
            drive(T_JAL, (c == 0), 1'b0);
            vectors++;
            if ({ctrl_vec(), sel_vec()} !== {exp_v[c], exp_s[c]}) begin
                miscompares++;
                $display("FAIL jal cycle %0d: got %b/%b expected %b/%b",
                         c, ctrl_vec(), sel_vec(), exp_v[c], exp_s[c]);
            end
        end
    endtask

    task automatic test_alu();
        logic [12:0] exp_v [5];
        logic [6:0]  op;
        logic [7:0]  exp_sel;
        for (int k = 0; k < 2; k++) begin
            op      = (k == 0) ? T_R : T_I;
            exp_sel = (k == 0) ? 8'b10_00_10_00 : 8'b10_01_10_00;
            exp_v   = '{V_F1, V_DEC, ((k == 0) ? V_EXR : V_EXI), V_ALUWB, V_F0};
            for (int c = 0; c < 5; c++) begin
                drive(op, (c == 0), 1'b0);
                vectors++;
                if (ctrl_vec() !== exp_v[c]) begin
                    miscompares++;
                    $display("FAIL alu%0d cycle %0d: got %b expected %b", k, c, ctrl_vec(), exp_v[c]);
                end
                if (c == 2) begin
                    vectors++;
                    if (sel_vec() !== exp_sel) begin
                        miscompares++;
                        $display("FAIL alu%0d_sel: got %b expected %b", k, sel_vec(), exp_sel);
                    end
                end
            end
        end
    endtask

    task automatic test_illegal();
        drive(T_SYS, 1'b1, 1'b0);
        drive(T_SYS, 1'b1, 1'b0);
        vectors++;
        if (ctrl_vec() !== V_DEC) begin
            miscompares++;
            $display("FAIL illegal_decode: got %b expected %b", ctrl_vec(), V_DEC);
        end
        for (int c = 0; c < 5; c++) begin
            drive((c == 0) ? T_SYS : T_LW, 1'b1, 1'b1);
            vectors++;
            if ({ctrl_vec(), o_halted, o_illegal} !== {V_HALT, 2'b11}) begin
                miscompares++;
                $display("FAIL illegal_halt cycle %0d: got %b/%b%b expected %b/11",
                         c, ctrl_vec(), o_halted, o_illegal, V_HALT);
            end
        end
    endtask

    // enters right after a reset release: that release cycle is FETCH wait #1
    task automatic test_ready_at_limit();
        for (int c = 0; c < 3; c++) drive(T_R, 1'b0, 1'b0);
        drive(T_R, 1'b1, 1'b0);
        vectors++;
        if (ctrl_vec() !== V_F1) begin
            miscompares++;
            $display("FAIL limit_ready: got %b expected %b", ctrl_vec(), V_F1);
        end
        drive(T_R, 1'b0, 1'b0);
        vectors++;
        if ({ctrl_vec(), o_halted} !== {V_DEC, 1'b0}) begin
            miscompares++;
            $display("FAIL limit_no_halt: got %b/%b expected %b/0", ctrl_vec(), o_halted, V_DEC);
        end
        drive(T_R, 1'b0, 1'b0);
        drive(T_R, 1'b0, 1'b0);
        drive(T_R, 1'b0, 1'b0);
        vectors++;
        if (ctrl_vec() !== V_F0) begin
            miscompares++;
            $display("FAIL limit_return: got %b expected %b", ctrl_vec(), V_F0);
        end
    endtask

    task automatic test_timeout_async();
        drive(T_LW, 1'b1, 1'b0);
        drive(T_LW, 1'b1, 1'b0);
        drive(T_LW, 1'b1, 1'b0);
        drive(T_LW, 1'b0, 1'b0);
        drive(T_LW, 1'b0, 1'b0);
        vectors++;
        if (ctrl_vec() !== {4'd3, 7'b1100000, 2'b00}) begin
            miscompares++;
            $display("FAIL memread_wait: got %b expected %b", ctrl_vec(), {4'd3, 7'b1100000, 2'b00});
        end
        #2 i_rst_n = 1'b0;
        #1;
        vectors++;
        if (ctrl_vec() !== V_F0) begin
            miscompares++;
            $display("FAIL async_reset: got %b expected %b", ctrl_vec(), V_F0);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(T_LW, 1'b0, 1'b0);
            vectors++;
            if ({ctrl_vec(), o_halted} !== {V_F0, 1'b0}) begin
                miscompares++;
                $display("FAIL timeout_wait cycle %0d: got %b/%b expected %b/0", c, ctrl_vec(), o_halted, V_F0);
            end
        end
        drive(T_LW, 1'b1, 1'b0);
        vectors++;
        if ({ctrl_vec(), o_halted, o_illegal} !== {V_HALT, 2'b10}) begin
            miscompares++;
            $display("FAIL timeout_halt: got %b/%b%b expected %b/10", ctrl_vec(), o_halted, o_illegal, V_HALT);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        i_rst_n     = 1'b0;
        i_op        = 7'd0;
        i_zero      = 1'b0;
        i_mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_sw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jal();
        test_alu();
        test_illegal();
        test_reset();
        test_ready_at_limit();
        test_timeout_async();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multi-cycle RV32I core: lw, sw, R-type, I-type ALU, beq, jal.
- Sequences one shared ALU and one unified instruction/data memory across several cycles per instruction.
- Drives every datapath select/enable except ALU function decode, which stays with the existing ALU decoder via o_aluop.
- Adds a memory ready handshake with timeout, and a sticky halt on illegal opcode or bus timeout.

Parameters:
- TIMEOUT_CYCLES, 16: maximum wait cycles for i_mem_ready in a memory state. 0 disables the timeout.
- CNT_W, 5: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  core clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_op  in  7  opcode field of the instruction register.
- i_zero  in  1  ALU zero flag.
- i_mem_ready  in  1  memory completes the current access this cycle.
- o_mem_req  out  1  memory access requested.
- o_memwrite  out  1  access is a write.
- o_adrsrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- o_irwrite  out  1  load instruction register and old-PC register.
- o_pcwrite  out  1  PC enable = pcupdate | (branch & i_zero).
- o_regwrite  out  1  register file write.
- o_resultsrc  out  2  result select: 00 = ALUOut, 01 = data register, 10 = ALU result.
- o_alusrca  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
- o_alusrcb  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- o_immsrc  out  2  immediate format.
- o_aluop  out  2  to ALU decoder.
- o_instret  out  1  one-cycle pulse on the final cycle of each instruction.
- o_halted  out  1  sticky halt.
- o_illegal  out  1  sticky: halt was caused by an illegal opcode.
- o_state  out  4  current state encoding, for debug.

Behaviour:
- Reset:
  - Asynchronous; state = FETCH, wait counter = 0, o_halted = 0, o_illegal = 0.
  - All other outputs are combinational from state and take FETCH values immediately.
  - Reset mid-instruction abandons the instruction; no partial writes are re-issued.
- Default for every output is 0 unless listed below.
- o_immsrc is combinational from i_op in all states: lw 00, I-ALU 00, sw 01, beq 10, jal 11, other 00.
- FETCH:
  - Outputs: mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10.
  - irwrite and pcupdate are asserted only in a cycle with i_mem_ready=1.
  - Next state: DECODE on ready, else stay.
- DECODE:
  - Outputs: alusrca=01, alusrcb=01, aluop=00.
  - Next state by i_op: lw/sw -> MEMADR, R -> EXECR, I-ALU -> EXECI, beq -> BEQ, jal -> JAL, other -> HALT with o_illegal set.
- MEMADR:
  - Outputs: alusrca=10, alusrcb=01, aluop=00.
  - Next state: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD:
  - Outputs: mem_req=1, adrsrc=1, resultsrc=00.
  - The datapath data register captures read data in the ready cycle.
  - Next state: MEMWB on ready.
- MEMWB:
  - Outputs: resultsrc=01, regwrite=1, instret=1.
  - Next state: FETCH.
- MEMWRITE:
  - Outputs: mem_req=1, memwrite=1, adrsrc=1, resultsrc=00. All are held stable until ready.
  - instret=1 in the ready cycle.
  - Next state: FETCH on ready.
- EXECR: alusrca=10, alusrcb=00, aluop=10; next ALUWB.
- EXECI: alusrca=10, alusrcb=01, aluop=10; next ALUWB.
- ALUWB: resultsrc=00, regwrite=1, instret=1; next FETCH.
- BEQ:
  - Outputs: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1, instret=1.
  - Next state: FETCH.
- JAL:
  - Outputs: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1.
  - Next state: ALUWB.
- Wait counter and timeout:
  - Counter increments each cycle a memory state sees ready=0, and clears on ready or state change.
  - If TIMEOUT_CYCLES>0 and counter == TIMEOUT_CYCLES with ready still 0: next state HALT, o_illegal stays 0.
  - Ready arriving in the same cycle as the limit wins; there is no halt.
- HALT:
  - All enables and o_mem_req are 0; o_halted=1.
  - Exit only by reset.
- Cycle counts with zero-wait memory:
  - lw 5, sw 4, R/I 4, beq 3, jal 4 (FETCH, DECODE, JAL, ALUWB).

Decomposition:
- Shared package mc_pkg holds:
  - state_t enum with fixed 4-bit encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, HALT=15.
  - Opcode localparams.
  - Select-value localparams for resultsrc, alusrca, alusrcb, immsrc and aluop.
- Natural sub-module: mem_wait_timer, containing the wait counter and timeout compare.

Test Plan:
- lw, ready always 1 -> states 0,1,2,3,4,0. regwrite=1 and resultsrc=01 only in MEMWB; instret exactly one pulse.
- sw with ready held 0 for 3 cycles -> MEMWRITE lasts 4 cycles. memwrite/adrsrc stay 1 throughout; instret only in the ready cycle.
- beq with i_zero=1 -> o_pcwrite=1 in BEQ. beq with i_zero=0 -> o_pcwrite=0; both return to FETCH.
- jal -> FETCH, DECODE, JAL (pcwrite=1, alusrca=01, alusrcb=10), ALUWB (regwrite=1); o_immsrc=11 throughout.
- Opcode 7'b1110011 in DECODE -> HALT with o_halted=1, o_illegal=1. Later ready pulses and opcodes are ignored until reset.
- TIMEOUT_CYCLES=4 with ready stuck 0 in FETCH -> HALT after 5 FETCH cycles, o_illegal=0. Asserting i_rst_n=0 mid-wait returns to FETCH asynchronously.
